// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: system register numbers,
// sequencer state encoding and IRQ source indices.
package intr_ctrl_pkg;

   localparam logic [2:0] SREG_SCS = 3'd0;
   localparam logic [2:0] SREG_SII = 3'd1;
   localparam logic [2:0] SREG_SRA = 3'd2;
   localparam logic [2:0] SREG_SR0 = 3'd3;
   localparam logic [2:0] SREG_SR1 = 3'd4;

   localparam int IRQ_TIMER = 0;
   localparam int IRQ_KEYS  = 1;
   localparam int IRQ_SWS   = 2;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_ENTER   = 2'd2,
      ST_HANDLER = 2'd3
   } intr_state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module intr_prio_enc #(
   parameter int NSRC   = 3,
   parameter int IDBITS = 2
) (
   input  logic [NSRC-1:0]   req,
   output logic              valid,
   output logic [IDBITS-1:0] idx
);

   // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) idx = IDBITS'(i);
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt sequencer: arbitrates level IRQs, waits for a safe redirect point,
// pulses take for one cycle and owns the IE/OIE/SRA/SII system registers.
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int DBITS  = 16,
   parameter int NSRC   = 3,
   parameter int IDBITS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NSRC-1:0]  irq,
   input  logic             redir_ok,
   input  logic [DBITS-1:0] resume_pc,
   input  logic             reti_m,
   input  logic             wsr_m,
   input  logic [2:0]       wsr_sel,
   input  logic [DBITS-1:0] wsr_data,
   output logic             take,
   output logic             ie,
   output logic             oie,
   output logic [DBITS-1:0] sra,
   output logic [DBITS-1:0] sii,
   output logic             busy
);

   intr_state_t       state;
   logic [NSRC-1:0]   pend;
   logic              win_valid;
   logic [IDBITS-1:0] win_idx;
   logic [IDBITS-1:0] win_id;
   logic              wsr_scs;
   logic              wsr_sra;
   logic              ie_nxt;

   assign pend = ie ? irq : '0;

   intr_prio_enc #(
      .NSRC   (NSRC),
      .IDBITS (IDBITS)
   ) u_prio (
      .req   (pend),
      .valid (win_valid),
      .idx   (win_idx)
   );

   // RETI has priority over a WSR retiring in the same cycle.
   assign wsr_scs = wsr_m && !reti_m && (wsr_sel == SREG_SCS);
   assign wsr_sra = wsr_m && !reti_m && (wsr_sel == SREG_SRA);

   always_comb begin
      ie_nxt = ie;
      if (reti_m)       ie_nxt = oie;
      else if (wsr_scs) ie_nxt = wsr_data[0];
   end

   assign take = (state == ST_ENTER);
   assign busy = (state != ST_RUN);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_RUN;
         ie     <= 1'b0;
         oie    <= 1'b0;
         sra    <= '0;
         sii    <= '0;
         win_id <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (win_valid) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // Spurious request or IE turned off: abandon without side effects.
               if (!ie_nxt || !win_valid) begin
                  state <= ST_RUN;
               end else if (redir_ok) begin
                  state  <= ST_ENTER;
                  win_id <= win_idx;
               end
            end
            ST_ENTER: begin
               state <= ST_HANDLER;
            end
            ST_HANDLER: begin
               if (reti_m) state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase

         if (state == ST_ENTER) begin
            sra <= resume_pc;
            sii <= DBITS'(win_id);
            oie <= ie;
            ie  <= 1'b0;
         end else begin
            ie <= ie_nxt;
            if (wsr_scs) oie <= wsr_data[1];
            if (wsr_sra) sra <= wsr_data;
         end
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl: each task drives one scenario and checks
// outputs one time unit after the rising edge.
module tb_intr_ctrl;
   import intr_ctrl_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [2:0]  irq;
   logic        redir_ok;
   logic [15:0] resume_pc;
   logic        reti_m;
   logic        wsr_m;
   logic [2:0]  wsr_sel;
   logic [15:0] wsr_data;
   logic        take;
   logic        ie;
   logic        oie;
   logic [15:0] sra;
   logic [15:0] sii;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   intr_ctrl #(.DBITS(16), .NSRC(3), .IDBITS(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq       (irq),
      .redir_ok  (redir_ok),
      .resume_pc (resume_pc),
      .reti_m    (reti_m),
      .wsr_m     (wsr_m),
      .wsr_sel   (wsr_sel),
      .wsr_data  (wsr_data),
      .take      (take),
      .ie        (ie),
      .oie       (oie),
      .sra       (sra),
      .sii       (sii),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wsr(input logic [2:0] sel, input logic [15:0] data);
      wsr_m = 1'b1; wsr_sel = sel; wsr_data = data;
      tick();
      wsr_m = 1'b0;
   endtask

   task automatic reti();
      reti_m = 1'b1;
      tick();
      reti_m = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; irq = '0; redir_ok = 1'b0; resume_pc = '0;
      reti_m = 1'b0; wsr_m = 1'b0; wsr_sel = '0; wsr_data = '0;
      repeat (2) tick();
      n_checks++; if (take !== 1'b0) begin n_fail++; $display("FAIL rst_take: got %b want 0", take); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_checks++; if ({ie, oie} !== 2'b00) begin n_fail++; $display("FAIL rst_ie_oie: got %b want 00", {ie, oie}); end
      n_checks++; if (sra !== 16'h0000) begin n_fail++; $display("FAIL rst_sra: got %h want 0000", sra); end
      n_checks++; if (sii !== 16'h0000) begin n_fail++; $display("FAIL rst_sii: got %h want 0000", sii); end
      rst_n = 1'b1;
      // IE still 0: a request must be ignored.
      irq = 3'b111; redir_ok = 1'b1;
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ie0_busy: got %b want 0", busy); end
      irq = '0;
   endtask

   task automatic test_take_basic();
      wsr(SREG_SCS, 16'h0001);
      n_checks++; if (ie !== 1'b1) begin n_fail++; $display("FAIL t1_ie_set: got %b want 1", ie); end
      irq = 3'b110; redir_ok = 1'b1; resume_pc = 16'h0208;
      tick();
      n_checks++; if ({busy, take} !== 2'b10) begin n_fail++; $display("FAIL t1_drain: got busy,take=%b want 10", {busy, take}); end
      tick();
      n_checks++; if (take !== 1'b1) begin n_fail++; $display("FAIL t1_take: got %b want 1", take); end
      tick();
      n_checks++; if (take !== 1'b0) begin n_fail++; $display("FAIL t1_take_pulse: got %b want 0", take); end
      n_checks++; if (sii !== 16'h0001) begin n_fail++; $display("FAIL t1_sii: got %h want 0001", sii); end
      n_checks++; if (sra !== 16'h0208) begin n_fail++; $display("FAIL t1_sra: got %h want 0208", sra); end
      n_checks++; if ({ie, oie} !== 2'b01) begin n_fail++; $display("FAIL t1_ie_oie: got %b want 01", {ie, oie}); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_handler_busy: got %b want 1", busy); end
      irq = '0;
      reti();
      n_checks++; if ({busy, ie, oie} !== 3'b011) begin n_fail++; $display("FAIL t1_reti: got busy,ie,oie=%b want 011", {busy, ie, oie}); end
   endtask

   task automatic test_redir_wait();
      irq = 3'b001; redir_ok = 1'b0; resume_pc = 16'h0300;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if ({busy, take} !== 2'b10) begin n_fail++; $display("FAIL t2_wait%0d: got busy,take=%b want 10", i, {busy, take}); end
      end
      redir_ok = 1'b1;
      tick();
      n_checks++; if (take !== 1'b1) begin n_fail++; $display("FAIL t2_take: got %b want 1", take); end
      tick();
      n_checks++; if (sii !== 16'h0000) begin n_fail++; $display("FAIL t2_sii: got %h want 0000", sii); end
      n_checks++; if (sra !== 16'h0300) begin n_fail++; $display("FAIL t2_sra: got %h want 0300", sra); end
      irq = '0;
      reti();
   endtask

   task automatic test_no_nesting();
      irq = 3'b111; redir_ok = 1'b1; resume_pc = 16'h0400;
      repeat (3) tick();
      n_checks++; if ({busy, take, ie, oie} !== 4'b1001) begin n_fail++; $display("FAIL t3_handler: got busy,take,ie,oie=%b want 1001", {busy, take, ie, oie}); end
      n_checks++; if (sii !== 16'h0000) begin n_fail++; $display("FAIL t3_sii: got %h want 0000", sii); end
      wsr(SREG_SCS, 16'h0001);
      n_checks++; if ({ie, oie} !== 2'b10) begin n_fail++; $display("FAIL t3_wsr_scs: got ie,oie=%b want 10", {ie, oie}); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if ({busy, take} !== 2'b10) begin n_fail++; $display("FAIL t3_nonest%0d: got busy,take=%b want 10", i, {busy, take}); end
      end
      wsr(SREG_SCS, 16'h0003);
      reti();
      n_checks++; if ({busy, ie, oie} !== 3'b011) begin n_fail++; $display("FAIL t3_reti: got busy,ie,oie=%b want 011", {busy, ie, oie}); end
      resume_pc = 16'h0410;
      tick();
      n_checks++; if ({busy, take} !== 2'b10) begin n_fail++; $display("FAIL t3_redrain: got busy,take=%b want 10", {busy, take}); end
      tick();
      n_checks++; if (take !== 1'b1) begin n_fail++; $display("FAIL t3_retake: got %b want 1", take); end
      tick();
      n_checks++; if (sra !== 16'h0410) begin n_fail++; $display("FAIL t3_sra: got %h want 0410", sra); end
      irq = '0;
      reti();
   endtask

   task automatic test_spurious();
      irq = 3'b100; redir_ok = 1'b0; resume_pc = 16'h0BAD;
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t4_drain: got %b want 1", busy); end
      irq = '0;
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t4_back_run: got %b want 0", busy); end
      redir_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if ({busy, take} !== 2'b00) begin n_fail++; $display("FAIL t4_idle%0d: got busy,take=%b want 00", i, {busy, take}); end
      end
      n_checks++; if (sra !== 16'h0410) begin n_fail++; $display("FAIL t4_sra: got %h want 0410", sra); end
      n_checks++; if (sii !== 16'h0000) begin n_fail++; $display("FAIL t4_sii: got %h want 0000", sii); end
      n_checks++; if (ie !== 1'b1) begin n_fail++; $display("FAIL t4_ie: got %b want 1", ie); end
   endtask

   task automatic test_wsr_in_enter();
      irq = 3'b010; redir_ok = 1'b1; resume_pc = 16'h0500;
      repeat (2) tick();
      n_checks++; if (take !== 1'b1) begin n_fail++; $display("FAIL t5_take: got %b want 1", take); end
      wsr(SREG_SRA, 16'h1234);
      n_checks++; if (sra !== 16'h0500) begin n_fail++; $display("FAIL t5_sra_enter: got %h want 0500", sra); end
      n_checks++; if (sii !== 16'h0001) begin n_fail++; $display("FAIL t5_sii: got %h want 0001", sii); end
      wsr(SREG_SRA, 16'h1234);
      n_checks++; if (sra !== 16'h1234) begin n_fail++; $display("FAIL t5_sra_handler: got %h want 1234", sra); end
      irq = '0;
      // RETI and WSR in the same cycle: only the RETI takes effect.
      wsr_m = 1'b1; wsr_sel = SREG_SCS; wsr_data = 16'h0000;
      reti();
      wsr_m = 1'b0;
      n_checks++; if ({busy, ie, oie} !== 3'b011) begin n_fail++; $display("FAIL t5_reti_wins: got busy,ie,oie=%b want 011", {busy, ie, oie}); end
   endtask

   task automatic test_reset_mid();
      irq = 3'b001; redir_ok = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t6_drain: got %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({take, busy, ie, oie} !== 4'b0000) begin n_fail++; $display("FAIL t6_rst_drain: got take,busy,ie,oie=%b want 0000", {take, busy, ie, oie}); end
      n_checks++; if ({sra, sii} !== 32'h0) begin n_fail++; $display("FAIL t6_rst_drain_regs: got sra=%h sii=%h want 0", sra, sii); end
      #1 rst_n = 1'b1;
      redir_ok = 1'b1;
      tick();
      n_checks++; if ({take, busy} !== 2'b00) begin n_fail++; $display("FAIL t6_after_drain: got take,busy=%b want 00", {take, busy}); end
      wsr(SREG_SCS, 16'h0001);
      resume_pc = 16'h0600;
      repeat (2) tick();
      n_checks++; if (take !== 1'b1) begin n_fail++; $display("FAIL t6_enter: got %b want 1", take); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({take, busy, ie, oie} !== 4'b0000) begin n_fail++; $display("FAIL t6_rst_enter: got take,busy,ie,oie=%b want 0000", {take, busy, ie, oie}); end
      n_checks++; if ({sra, sii} !== 32'h0) begin n_fail++; $display("FAIL t6_rst_enter_regs: got sra=%h sii=%h want 0", sra, sii); end
      #1 rst_n = 1'b1;
      repeat (2) tick();
      n_checks++; if ({take, busy, sra} !== 18'h0) begin n_fail++; $display("FAIL t6_after_enter: got take,busy=%b sra=%h want 0", {take, busy}, sra); end
      irq = '0;
   endtask

   initial begin
      test_reset();
      test_take_basic();
      test_redir_wait();
      test_no_nesting();
      test_spurious();
      test_wsr_in_enter();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
